// File: rtl/dmem_responder.sv
// Word-addressed data memory responder with a req/ack handshake and a programmable wait.
// A request is captured in IDLE, launched on the next edge, then ACK pulses once.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no access in flight; captures a request, launches it next edge
// ST_WAIT | wait_cnt counting down to zero before the response
// ST_ACK  | one-cycle response: ack, err, rdata valid; stores commit here
module dmem_responder #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic        ack,
  output logic [15:0] rdata,
  output logic        err,
  output logic        busy
);

  localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              pending;
  logic              cap_we;
  logic [15:0]       cap_addr;
  logic [15:0]       cap_wdata;
  logic [3:0]        wait_cnt;
  logic              accept;
  logic              launch;
  logic [7:0]        word_idx;
  logic [IDX_W-1:0]  mem_idx;
  logic              fault;
  logic              mem_wr;
  logic [15:0]       rd_word;

  logic [15:0] mem [0:DEPTH-1];

  // A request is captured only once per IDLE visit; pending blocks re-capture
  // while the captured access is being launched.
  assign accept = (state == ST_IDLE) && !pending && req;
  assign launch = (state == ST_IDLE) && pending;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending   <= 1'b0;
      cap_we    <= 1'b0;
      cap_addr  <= 16'd0;
      cap_wdata <= 16'd0;
      wait_cnt  <= 4'd0;
    end else if (accept) begin
      pending   <= 1'b1;
      cap_we    <= we;
      cap_addr  <= addr;
      cap_wdata <= wdata;
      wait_cnt  <= WAIT_LOAD;
    end else if (launch) begin
      pending <= 1'b0;
    end else if ((state == ST_WAIT) && (wait_cnt != 4'd0)) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ack       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pending) begin
          state_nxt = (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACK;
        end
      end
      ST_WAIT: begin
        if (wait_cnt == 4'd0) begin
          state_nxt = ST_ACK;
        end
      end
      ST_ACK: begin
        ack       = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Misaligned, beyond the array, or above the 512-byte window all fault.
  assign word_idx = cap_addr[8:1];
  assign mem_idx  = cap_addr[IDX_W:1];
  assign fault    = cap_addr[0] || (cap_addr[15:9] != 7'd0) || (32'(word_idx) >= DEPTH);

  assign busy    = pending || (state != ST_IDLE);
  assign err     = ack && fault;
  assign rd_word = mem[mem_idx];
  assign rdata   = (ack && !fault && !cap_we) ? rd_word : 16'd0;

  // Stores commit on the edge leaving ACK; an async reset pulls state out of
  // ACK first, so an abandoned access never writes.
  assign mem_wr = (state == ST_ACK) && cap_we && !fault;

  always_ff @(posedge clock) begin
    if (mem_wr) begin
      mem[mem_idx] <= cap_wdata;
    end
  end

endmodule
